// File: rtl/board_renderer_if.sv
// Video-side bus of the board renderer: pixel position and qualifiers from the
// sync generator, the glyph ROM lookup, and the resulting pixel colour.
interface board_renderer_if #(
  parameter int TILE_BITS = 4,
  parameter int CELL_LOG2 = 6
);
  logic                 frame_start;
  logic [9:0]           x;
  logic [9:0]           y;
  logic                 pixel_en;
  logic [TILE_BITS-1:0] glyph_index;
  logic [CELL_LOG2-1:0] glyph_x;
  logic [CELL_LOG2-1:0] glyph_y;
  logic                 glyph_pixel;
  logic [5:0]           rrggbb;

  // Timing/ROM side: drives position and glyph data, consumes colour.
  modport master (
    output frame_start, x, y, pixel_en, glyph_pixel,
    input  glyph_index, glyph_x, glyph_y, rrggbb
  );

  // Renderer side.
  modport slave (
    input  frame_start, x, y, pixel_en, glyph_pixel,
    output glyph_index, glyph_x, glyph_y, rrggbb
  );
endinterface

// File: rtl/board_renderer.sv
// Two-stage pipelined renderer for an N x N 2048 board. Draws from a grid
// snapshot taken at frame start, fades newly spawned tiles over a few frames,
// and looks glyphs up in an external combinational font ROM.
module board_renderer #(
  parameter int GRID_N      = 4,
  parameter int CELL_LOG2   = 6,
  parameter int TILE_BITS   = 4,
  parameter int BOARD_X     = 192,
  parameter int BOARD_Y     = 128,
  parameter int FADE_FRAMES = 7
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [GRID_N*GRID_N*TILE_BITS-1:0]  grid,
  input  logic [GRID_N*GRID_N-1:0]            new_tiles,
  input  logic                                new_tiles_valid,
  input  logic                                debug_mode,
  board_renderer_if.slave                     bus
);

  localparam int CELLS   = GRID_N * GRID_N;
  localparam int IDX_W   = $clog2(GRID_N);
  localparam int BOARD_W = GRID_N << CELL_LOG2;
  localparam int BOARD_H = GRID_N << CELL_LOG2;
  // The debug bar extends 64 px either side of the board; clamp at column 0.
  localparam int DBG_LO  = (BOARD_X >= 64) ? BOARD_X - 64 : 0;
  localparam int DBG_HI  = BOARD_X + BOARD_W + 64;

  logic [CELLS*TILE_BITS-1:0] shadow;
  logic [CELLS-1:0]           fade_mask;
  logic [2:0]                 fade_cnt;

  // Stage 1 combinational decode
  logic [9:0]           bx, by;
  logic [IDX_W-1:0]     cell_x, cell_y;
  logic [2*IDX_W-1:0]   cell_idx;
  logic [CELL_LOG2-1:0] rel_x, rel_y;
  logic                 in_x, in_y, outline, is_new, debug_rect;
  logic [11:0]          x_ext, y_ext;

  // Stage 1 registers
  logic       board_area_d, outline_d, is_new_d, debug_rect_d, pixel_en_d;
  logic [5:0] xdbg_d;

  // Stage 2 combinational colour
  logic [5:0] font, rgb_next;

  // Grid snapshot: only updated at frame start so the picture never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               shadow <= '0;
    else if (bus.frame_start) shadow <= grid;
  end

  // Fade state: a new-tile load restarts the fade and beats a same-cycle
  // frame decrement; the mask clears on the last decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fade_mask <= '0;
      fade_cnt  <= '0;
    end else if (new_tiles_valid) begin
      fade_mask <= new_tiles;
      fade_cnt  <= 3'(FADE_FRAMES);
    end else if (bus.frame_start && fade_cnt != 3'd0) begin
      fade_cnt <= fade_cnt - 3'd1;
      if (fade_cnt == 3'd1) fade_mask <= '0;
    end
  end

  assign x_ext    = {2'b00, bus.x};
  assign y_ext    = {2'b00, bus.y};
  assign bx       = bus.x - 10'(BOARD_X);
  assign by       = bus.y - 10'(BOARD_Y);
  assign cell_x   = IDX_W'(bx >> CELL_LOG2);
  assign cell_y   = IDX_W'(by >> CELL_LOG2);
  // GRID_N is a power of two, so cy*GRID_N+cx is a plain concatenation.
  assign cell_idx = {cell_y, cell_x};
  assign rel_x    = bx[CELL_LOG2-1:0];
  assign rel_y    = by[CELL_LOG2-1:0];
  assign in_x     = (x_ext >= 12'(BOARD_X)) && (x_ext < 12'(BOARD_X + BOARD_W));
  assign in_y     = (y_ext >= 12'(BOARD_Y)) && (y_ext < 12'(BOARD_Y + BOARD_H));
  // Outline is relative to the board origin, not to absolute screen columns.
  assign outline  = (rel_x == '0) || (rel_x == '1) || (rel_y == '0) || (rel_y == '1);
  assign is_new   = (fade_cnt != 3'd0) && fade_mask[cell_idx];
  assign debug_rect = (x_ext >= 12'(DBG_LO)) && (x_ext < 12'(DBG_HI)) &&
                      (bus.y >= 10'd16) && (bus.y < 10'd32);

  // Stage 1: register the glyph lookup and the per-pixel flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.glyph_index <= '0;
      bus.glyph_x     <= '0;
      bus.glyph_y     <= '0;
      board_area_d    <= 1'b0;
      outline_d       <= 1'b0;
      is_new_d        <= 1'b0;
      debug_rect_d    <= 1'b0;
      pixel_en_d      <= 1'b0;
      xdbg_d          <= '0;
    end else begin
      bus.glyph_index <= shadow[int'(cell_idx)*TILE_BITS +: TILE_BITS];
      bus.glyph_x     <= rel_x;
      bus.glyph_y     <= rel_y;
      board_area_d    <= in_x && in_y;
      outline_d       <= outline;
      is_new_d        <= is_new;
      debug_rect_d    <= debug_rect;
      pixel_en_d      <= bus.pixel_en;
      xdbg_d          <= bus.x[8:3];
    end
  end

  // Stage 2 colour priority; fade_cnt is taken live, which only shifts tint.
  always_comb begin
    font     = 6'b001111 ^ (is_new_d ? {3'b000, fade_cnt} : 6'b000000);
    rgb_next = 6'b000000;
    if (!pixel_en_d)                         rgb_next = 6'b000000;
    else if (board_area_d && bus.glyph_pixel) rgb_next = font;
    else if (board_area_d && outline_d)      rgb_next = 6'b111111;
    else if (board_area_d)                   rgb_next = 6'b000000;
    else if (debug_mode && debug_rect_d)     rgb_next = xdbg_d;
  end

  // Stage 2 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rrggbb <= '0;
    else        bus.rrggbb <= rgb_next;
  end

endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: a default 4x4 instance and an 8x8/32px instance
// share the pixel stream; expected colours/glyph outputs go to a scoreboard.
module tb_board_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic [63:0]  grid_a = '0;
  logic [15:0]  nt_a = '0;
  logic [255:0] grid_b = '0;
  logic [63:0]  nt_b = '0;
  logic         ntv = 1'b0;
  logic [9:0]   x_in = '0, y_in = '0;
  logic         pe_in = 1'b0, fs_in = 1'b0, gp_in = 1'b0, dbg_in = 1'b0;
  logic         gp_d = 1'b0, dbg_d = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  board_renderer_if #(.TILE_BITS(4), .CELL_LOG2(6)) bus_a ();
  board_renderer_if #(.TILE_BITS(4), .CELL_LOG2(5)) bus_b ();

  assign bus_a.x = x_in;        assign bus_b.x = x_in;
  assign bus_a.y = y_in;        assign bus_b.y = y_in;
  assign bus_a.pixel_en = pe_in; assign bus_b.pixel_en = pe_in;
  assign bus_a.frame_start = fs_in; assign bus_b.frame_start = fs_in;
  assign bus_a.glyph_pixel = gp_d;  assign bus_b.glyph_pixel = gp_d;

  board_renderer dut_a (
    .clk(clk), .rst_n(rst_n), .grid(grid_a), .new_tiles(nt_a),
    .new_tiles_valid(ntv), .debug_mode(dbg_d), .bus(bus_a)
  );

  board_renderer #(.GRID_N(8), .CELL_LOG2(5), .TILE_BITS(4), .BOARD_X(64),
                   .BOARD_Y(128), .FADE_FRAMES(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .grid(grid_b), .new_tiles(nt_b),
    .new_tiles_valid(1'b0), .debug_mode(dbg_d), .bus(bus_b)
  );

  // ROM-data and debug-switch alignment: they belong to the pixel that is in
  // stage 2, one clock after it was presented.
  always @(posedge clk) begin
    gp_d  <= gp_in;
    dbg_d <= dbg_in;
    cyc   <= cyc + 1;
  end

  typedef struct {
    logic       sel;
    logic [9:0] x, y;
    logic       pe, gp, dbg;
    logic [5:0] rgb;
    logic       chk_g;
    logic [3:0] gi;
    logic [5:0] gx, gy;
  } vec_t;

  typedef struct {
    int         due;
    int         id;
    logic       sel;
    logic [5:0] rgb;
    logic       chk_g;
    logic [3:0] gi;
    logic [5:0] gx, gy;
  } exp_t;

  exp_t sb[$];
  logic [3:0] pa_gi = '0, pb_gi = '0;
  logic [5:0] pa_gx = '0, pa_gy = '0, pb_gx = '0, pb_gy = '0;

  function automatic vec_t mk(input int sel, input int x, input int y, input bit pe,
                              input bit gp, input bit dbg, input logic [5:0] rgb,
                              input bit cg, input int gi, input int gx, input int gy);
    vec_t v;
    v.sel = sel[0]; v.x = 10'(x); v.y = 10'(y); v.pe = pe; v.gp = gp; v.dbg = dbg;
    v.rgb = rgb; v.chk_g = cg; v.gi = 4'(gi); v.gx = 6'(gx); v.gy = 6'(gy);
    return v;
  endfunction

  // Monitor: pop due entries; glyph outputs are compared from the previous
  // cycle, where the pixel's stage-1 values were visible.
  always @(negedge clk) begin
    exp_t e;
    logic [5:0] act_rgb;
    logic [15:0] act_g, exp_g;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      act_rgb = e.sel ? bus_b.rrggbb : bus_a.rrggbb;
      checks++;
      if (e.due != cyc || act_rgb !== e.rgb) begin
        errors++;
        $display("FAIL vec%0d rgb: got %b expected %b (due %0d now %0d)", e.id, act_rgb, e.rgb, e.due, cyc);
      end
      if (e.chk_g) begin
        act_g = e.sel ? {pb_gi, pb_gx, pb_gy} : {pa_gi, pa_gx, pa_gy};
        exp_g = {e.gi, e.gx, e.gy};
        checks++;
        if (act_g !== exp_g) begin
          errors++;
          $display("FAIL vec%0d glyph: got idx=%0d x=%0d y=%0d expected idx=%0d x=%0d y=%0d",
                   e.id, act_g[15:12], act_g[11:6], act_g[5:0], e.gi, e.gx, e.gy);
        end
      end
      $display("vec%0d dut_%s rgb=%b", e.id, e.sel ? "b" : "a", act_rgb);
    end
    pa_gi = bus_a.glyph_index; pa_gx = bus_a.glyph_x; pa_gy = bus_a.glyph_y;
    pb_gi = bus_b.glyph_index; pb_gx = {1'b0, bus_b.glyph_x}; pb_gy = {1'b0, bus_b.glyph_y};
  end

  task automatic drive(input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    x_in = v.x; y_in = v.y; pe_in = v.pe; gp_in = v.gp; dbg_in = v.dbg;
    e.due = cyc + 2; e.id = id; e.sel = v.sel; e.rgb = v.rgb; e.chk_g = v.chk_g;
    e.gi = v.gi; e.gx = v.gx; e.gy = v.gy;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    pe_in = 1'b0; gp_in = 1'b0; dbg_in = 1'b0;
  endtask

  task automatic flush();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL flush: %0d entries pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic pulse_fs();
    @(negedge clk); fs_in = 1'b1;
    @(negedge clk); fs_in = 1'b0;
  endtask

  task automatic pulse_nt(input bit with_fs);
    @(negedge clk); ntv = 1'b1; fs_in = with_fs;
    @(negedge clk); ntv = 1'b0; fs_in = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("%s ok = %0h", nm, act);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[20];
  int nid = 100;

  initial begin
    vecs[0]  = mk(0, 202, 138, 1, 1, 0, 6'b001111, 1, 1, 10, 10);
    vecs[1]  = mk(0, 255, 133, 1, 0, 0, 6'b111111, 1, 1, 63, 5);
    vecs[2]  = mk(0, 191, 133, 1, 0, 0, 6'b000000, 0, 0, 0, 0);
    vecs[3]  = mk(0, 140, 20,  1, 0, 1, 6'b010001, 0, 0, 0, 0);
    vecs[4]  = mk(0, 140, 20,  1, 0, 0, 6'b000000, 0, 0, 0, 0);
    vecs[5]  = mk(0, 202, 138, 0, 1, 0, 6'b000000, 1, 1, 10, 10);
    vecs[6]  = mk(0, 276, 222, 1, 0, 0, 6'b000000, 1, 3, 20, 30);
    vecs[7]  = mk(0, 276, 222, 1, 1, 0, 6'b001111, 1, 3, 20, 30);
    vecs[8]  = mk(0, 192, 150, 1, 0, 0, 6'b111111, 1, 1, 0, 22);
    vecs[9]  = mk(0, 202, 127, 1, 1, 0, 6'b000000, 0, 0, 0, 0);
    vecs[10] = mk(0, 200, 383, 1, 0, 0, 6'b111111, 1, 0, 8, 63);
    vecs[11] = mk(0, 511, 16,  1, 0, 1, 6'b111111, 0, 0, 0, 0);
    vecs[12] = mk(0, 140, 32,  1, 0, 1, 6'b000000, 0, 0, 0, 0);
    vecs[13] = mk(0, 127, 20,  1, 0, 1, 6'b000000, 0, 0, 0, 0);
    vecs[14] = mk(0, 448, 200, 1, 1, 0, 6'b000000, 0, 0, 0, 0);
    vecs[15] = mk(1, 292, 228, 1, 1, 0, 6'b001111, 1, 9, 4, 4);
    vecs[16] = mk(1, 292, 228, 1, 0, 0, 6'b000000, 1, 9, 4, 4);
    vecs[17] = mk(1, 319, 228, 1, 0, 0, 6'b111111, 1, 9, 31, 4);
    vecs[18] = mk(1, 292, 228, 0, 1, 0, 6'b000000, 0, 0, 0, 0);
    vecs[19] = mk(1, 320, 228, 1, 1, 0, 6'b000000, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rgb", 64'(bus_a.rrggbb), 64'd0);
    chk("reset_glyph", 64'({bus_a.glyph_index, bus_a.glyph_x, bus_a.glyph_y}), 64'd0);
    chk("reset_shadow", dut_a.shadow, 64'd0);
    chk("reset_fade", 64'({dut_a.fade_mask, dut_a.fade_cnt}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    grid_a = '0; grid_a[3:0] = 4'd1; grid_a[5*4 +: 4] = 4'd3;
    grid_b = '0; grid_b[(3*8+7)*4 +: 4] = 4'd9;
    pulse_fs();

    // Table, streamed back to back
    for (int i = 0; i < 20; i++) drive(vecs[i], i);
    idle(); flush();

    // Fade of cell (1,1)
    nt_a = 16'h0020;
    pulse_nt(1'b0); #1;
    chk("fade_load_cnt", 64'(dut_a.fade_cnt), 64'd7);
    drive(mk(0, 276, 222, 1, 1, 0, 6'b001000, 1, 3, 20, 30), nid++);
    drive(mk(0, 202, 138, 1, 1, 0, 6'b001111, 1, 1, 10, 10), nid++);
    idle(); flush();
    repeat (3) pulse_fs();
    drive(mk(0, 276, 222, 1, 1, 0, 6'b001011, 1, 3, 20, 30), nid++);
    idle(); flush();
    repeat (4) pulse_fs();
    drive(mk(0, 276, 222, 1, 1, 0, 6'b001111, 1, 3, 20, 30), nid++);
    idle(); flush();
    chk("fade_done_mask", 64'(dut_a.fade_mask), 64'd0);
    pulse_fs(); #1;
    chk("fade_saturate", 64'(dut_a.fade_cnt), 64'd0);

    // Simultaneous load and frame start: load wins
    pulse_nt(1'b0);
    repeat (5) pulse_fs();
    #1;
    chk("fade_cnt_2", 64'(dut_a.fade_cnt), 64'd2);
    pulse_nt(1'b1); #1;
    chk("simul_cnt", 64'(dut_a.fade_cnt), 64'd7);
    chk("simul_mask", 64'(dut_a.fade_mask), 64'h20);
    drive(mk(0, 276, 222, 1, 1, 0, 6'b001000, 1, 3, 20, 30), nid++);
    idle(); flush();

    // Tear-free snapshot
    grid_a[3:0] = 4'd5;
    drive(mk(0, 202, 138, 1, 1, 0, 6'b001111, 1, 1, 10, 10), nid++);
    idle(); flush();
    pulse_fs();
    drive(mk(0, 202, 138, 1, 1, 0, 6'b001111, 1, 5, 10, 10), nid++);
    idle(); flush();

    // Asynchronous reset mid-line
    @(negedge clk);
    x_in = 10'd255; y_in = 10'd133; pe_in = 1'b1; gp_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_rgb", 64'(bus_a.rrggbb), 64'h3f);
    rst_n = 1'b0;
    #1;
    chk("async_rgb_a", 64'(bus_a.rrggbb), 64'd0);
    chk("async_glyph_a", 64'({bus_a.glyph_index, bus_a.glyph_x, bus_a.glyph_y}), 64'd0);
    chk("async_rgb_b", 64'(bus_b.rrggbb), 64'd0);
    chk("async_state", 64'({dut_a.fade_mask, dut_a.fade_cnt}), 64'd0);
    chk("async_shadow", dut_a.shadow, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(mk(0, 202, 138, 1, 1, 0, 6'b001111, 1, 0, 10, 10), nid++);
    idle(); flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_renderer.md
# board_renderer

Parametrised, pipelined pixel renderer for the 2048 game board. Generalises the current combinational board drawer to an N×N grid with configurable cell size, tile width and board position. Adds a tear-free grid snapshot, an internal per-frame new-tile fade counter and a registered two-stage pixel pipeline. It sits between the game-logic core (grid, new-tile mask) and the VGA sync generator (x/y, frame strobe), and drives an external glyph ROM (the number-font block).

## Interface

**Parameters**
- `GRID_N`, default 4: board is GRID_N×GRID_N cells; must be a power of two, 2..8.
- `CELL_LOG2`, default 6: cell size is 2^CELL_LOG2 pixels square.
- `TILE_BITS`, default 4: bits per cell (tile exponent; 0 = empty).
- `BOARD_X`, default 192: left edge of the board, in pixels.
- `BOARD_Y`, default 128: top edge of the board, in pixels.
- `FADE_FRAMES`, default 7: fade length in frames, 1..7.

**Ports**
- `clk`, in, 1: pixel clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `grid`, in, GRID_N²·TILE_BITS: cell (cx,cy) is at bit offset ((cy·GRID_N)+cx)·TILE_BITS.
- `new_tiles`, in, GRID_N²: mask of newly spawned tiles, indexed cy·GRID_N+cx.
- `new_tiles_valid`, in, 1: one-cycle pulse that loads `new_tiles` and restarts the fade.
- `frame_start`, in, 1: one-cycle pulse at the first vertical-blank line.
- `x`, in, 10: current pixel column.
- `y`, in, 10: current pixel row.
- `pixel_en`, in, 1: active-video qualifier.
- `debug_mode`, in, 1: enables the debug colour bar.
- `glyph_index`, out, TILE_BITS: tile value sent to the glyph ROM (registered).
- `glyph_x`, out, CELL_LOG2: cell-relative column sent to the glyph ROM (registered).
- `glyph_y`, out, CELL_LOG2: cell-relative row sent to the glyph ROM (registered).
- `glyph_pixel`, in, 1: combinational glyph ROM result for the current `glyph_*` outputs.
- `rrggbb`, out, 6: registered pixel colour.

## Operation

**Grid snapshot**
- The `shadow` register loads `grid` only on `frame_start`.
- All drawing uses `shadow`, so game updates mid-frame never tear.

**Fade state**
- State is `fade_mask` (GRID_N² bits) and `fade_cnt` (3 bits).
- On `new_tiles_valid`:
  - `fade_mask <= new_tiles`
  - `fade_cnt <= FADE_FRAMES`
- Else, on `frame_start` with `fade_cnt != 0`: `fade_cnt <= fade_cnt - 1`. On the decrement to 0, `fade_mask` clears.
- If `new_tiles_valid` and `frame_start` occur in the same cycle, the load wins and no decrement happens.
- The counter saturates at 0.

**Pipeline stage 1** (registers, from x/y)
- `bx = x - BOARD_X`, `by = y - BOARD_Y` (10-bit wrap).
- `board_area = x ≥ BOARD_X && x < BOARD_X + (GRID_N<<CELL_LOG2)`, and likewise for y.
- `cx = bx >> CELL_LOG2`, `cy = by >> CELL_LOG2`, each clog2(GRID_N) bits.
- `glyph_x = bx[CELL_LOG2-1:0]`, `glyph_y = by[CELL_LOG2-1:0]`.
- `glyph_index = shadow` cell value.
- `outline` is set when the cell-relative x or y equals 0 or 2^CELL_LOG2−1. Outlines are board-relative, not absolute-screen-relative.
- `is_new = fade_cnt != 0 && fade_mask[cy·GRID_N+cx]`.
- `debug_rect` covers x in [BOARD_X−64, BOARD_X+width+64) and y in [16,32).
- `x[8:3]` is carried forward for the debug bar.
- `pixel_en` is carried forward.

**Pipeline stage 2** (`rrggbb`), first matching rule wins:
1. `!pixel_en_d` gives 0.
2. `board_area_d && glyph_pixel` gives `font` = 6'b001111, XOR {3'b0, `fade_cnt`} when `is_new_d`.
3. `board_area_d && outline_d` gives 6'b111111.
4. `board_area_d` gives 0.
5. `debug_mode && debug_rect_d` gives `xdbg_d`.
6. Otherwise 0.

**Other rules**
- Empty cells (value 0) still assert `glyph_index` = 0. The ROM defines glyph 0 as blank.
- `fade_cnt` is sampled live in stage 2. A change during active video only shifts colour, which is acceptable.

## Timing

- Latency: x/y/`pixel_en` sampled at edge k produce `rrggbb` valid after edge k+2. Throughput is one pixel per clock.
- `glyph_*` change after edge k+1. `glyph_pixel` must settle within the same cycle; no ROM latency is permitted.
- `shadow` update takes effect for pixels sampled from the cycle after `frame_start`.
- Reset (asynchronous, any time, including mid-frame):
  - `rrggbb` = 0
  - `glyph_index`, `glyph_x`, `glyph_y` = 0
  - `shadow` = 0
  - `fade_mask` = 0, `fade_cnt` = 0
  - all pipeline flags = 0
- The first valid pixel appears 2 cycles after reset release.

## Test plan

- **Basic tile:** reset; set `grid` cell(0,0)=1; pulse `frame_start`; drive x=192+10, y=128+10 with glyph_pixel=1 → two cycles later `rrggbb`=6'b001111, and `glyph_index`=1, `glyph_x`=10, `glyph_y`=10 one cycle after.
- **Outline:** x=192+63, y=128+5, glyph_pixel=0 → 6'b111111. At x=191 with debug_mode=0 → 0. At x=140, y=20, debug_mode=1 → x[8:3]=6'b010001.
- **Fade:** `new_tiles_valid` with mask bit 5 set (cell (1,1)), glyph_pixel=1 → colour 001111^000111=001000. After 3 `frame_start` pulses → 001011. After 7 → 001111 and `fade_mask`=0.
- **Simultaneous events:** `new_tiles_valid` and `frame_start` in the same cycle while `fade_cnt`=2 → `fade_cnt`=7. Tear-free snapshot: change `grid` mid-frame → `glyph_index` unchanged until the next `frame_start`.
- **Parametrisation:** GRID_N=8, CELL_LOG2=5, BOARD_X=64 → cell (7,3) is at x=64+7·32+4 and reads grid bits [(3·8+7)·4 +: 4]. Also check that `pixel_en`=0 forces `rrggbb`=0.
- **Reset:** assert `rst_n`=0 mid-line → all outputs 0 immediately (asynchronous). After release, outputs are valid 2 clocks later.
